// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, FSM state and flag-index definitions for alu_mc
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_LSL = 3'd5,
    OP_LSR = 3'd6,
    OP_MUL = 3'd7
  } op_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } st_e;
  localparam int FL_N = 3;
  localparam int FL_Z = 2;
  localparam int FL_C = 1;
  localparam int FL_V = 0;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier, one partial product per step
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_o
);
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH:0]     acc;
  // prod_o is the value after the current step, so the final step's product is usable the same cycle
  assign acc    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  assign prod_o = {acc, p_q[WIDTH-1:1]};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q <= '0;
      p_q <= '0;
    end else if (load_i) begin
      a_q <= a_i;
      p_q <= {{WIDTH{1'b0}}, b_i};
    end else if (step_i) begin
      p_q <= prod_o;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result/flags and START/BUSY/DONE handshake
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       FUNC,
  input  logic             SETF,
  input  logic [WIDTH-1:0] OPERA,
  input  logic [WIDTH-1:0] OPERB,
  output logic [WIDTH-1:0] RESULT,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             BUSY,
  output logic             DONE
);
  localparam int MSB = WIDTH - 1;
  st_e                st_q, st_d;
  op_e                op_q;
  logic               setf_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q, res_d, ex_r;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [3:0]         fl_q, fl_d, fl_new;
  logic               done_q, done_d, ld, stp, fin, ex_c, ex_v;
  logic [WIDTH:0]     add_w, sub_w, lsl_w, lsr_w;
  logic [2*WIDTH-1:0] mul_p;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (ld),
    .step_i (stp),
    .a_i    (OPERA),
    .b_i    (OPERB),
    .prod_o (mul_p)
  );

  always_comb begin
    add_w = {1'b0, a_q} + {1'b0, b_q};
    sub_w = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
    lsl_w = {1'b0, a_q} << b_q[SHW-1:0];
    lsr_w = {a_q, 1'b0} >> b_q[SHW-1:0];
    ex_r  = '0;
    ex_c  = 1'b0;
    ex_v  = 1'b0;
    case (op_q)
      OP_ADD: begin
        {ex_c, ex_r} = add_w;
        ex_v = (a_q[MSB] == b_q[MSB]) & (ex_r[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        {ex_c, ex_r} = sub_w;
        ex_v = (a_q[MSB] != b_q[MSB]) & (ex_r[MSB] != a_q[MSB]);
      end
      OP_AND: ex_r = a_q & b_q;
      OP_OR:  ex_r = a_q | b_q;
      OP_XOR: ex_r = a_q ^ b_q;
      OP_LSL: {ex_c, ex_r} = lsl_w;
      OP_LSR: {ex_r, ex_c} = lsr_w;
      default: begin
        ex_r = mul_p[WIDTH-1:0];
        ex_c = |mul_p[2*WIDTH-1:WIDTH];
      end
    endcase
    fl_new       = '0;
    fl_new[FL_N] = ex_r[MSB];
    fl_new[FL_Z] = ~|ex_r;
    fl_new[FL_C] = ex_c;
    fl_new[FL_V] = ex_v;
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    fl_d   = fl_q;
    done_d = 1'b0;
    ld     = 1'b0;
    stp    = 1'b0;
    fin    = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (START) begin
          ld    = 1'b1;
          cnt_d = SHW'(WIDTH - 1);
          st_d  = (FUNC == OP_MUL) ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: fin = 1'b1;
      ST_MUL: begin
        stp   = 1'b1;
        fin   = (cnt_q == '0);
        cnt_d = fin ? cnt_q : cnt_q - 1'b1;
      end
      default: st_d = ST_IDLE;
    endcase
    if (fin) begin
      res_d  = ex_r;
      fl_d   = setf_q ? fl_new : fl_q;
      done_d = 1'b1;
      st_d   = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q   <= ST_IDLE;
      res_q  <= '0;
      fl_q   <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OP_ADD;
      setf_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      st_q   <= st_d;
      res_q  <= res_d;
      fl_q   <= fl_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      if (ld) begin
        op_q   <= op_e'(FUNC);
        setf_q <= SETF;
        a_q    <= OPERA;
        b_q    <= OPERB;
      end
    end
  end

  assign RESULT = res_q;
  assign N      = fl_q[FL_N];
  assign Z      = fl_q[FL_Z];
  assign C      = fl_q[FL_C];
  assign V      = fl_q[FL_V];
  assign BUSY   = (st_q != ST_IDLE);
  assign DONE   = done_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven vectors plus handshake/reset sequences for alu_mc
module tb_alu_mc;
  logic        CLK = 1'b0;
  logic        RST, START, SETF, N, Z, C, V, BUSY, DONE;
  logic [2:0]  FUNC;
  logic [31:0] OPERA, OPERB, RESULT;
  int checks = 0;
  int failures = 0;

  alu_mc #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .FUNC(FUNC), .SETF(SETF),
    .OPERA(OPERA), .OPERB(OPERB), .RESULT(RESULT),
    .N(N), .Z(Z), .C(C), .V(V), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  nzcv;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic op(input logic [2:0] f, input logic sf, input logic [31:0] a, input logic [31:0] b,
                    output int lat, output int busy);
    @(negedge CLK);
    START = 1'b1; FUNC = f; SETF = sf; OPERA = a; OPERB = b;
    @(posedge CLK);
    #1 START = 1'b0; OPERA = $urandom; OPERB = $urandom;
    lat = 0;
    busy = 0;
    @(negedge CLK);
    busy += int'(BUSY);
    while (!DONE && lat < 100) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (!DONE) busy += int'(BUSY);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[15];
    int lat, busy, dones;
    vt[0]  = '{3'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1001, 1};
    vt[1]  = '{3'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0110, 1};
    vt[2]  = '{3'd1, 32'h5,        32'h5,        32'h0,        4'b0110, 1};
    vt[3]  = '{3'd1, 32'h3,        32'h5,        32'hFFFFFFFE, 4'b1000, 1};
    vt[4]  = '{3'd1, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0011, 1};
    vt[5]  = '{3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 1};
    vt[6]  = '{3'd3, 32'h0,        32'h0,        32'h0,        4'b0100, 1};
    vt[7]  = '{3'd4, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 4'b1000, 1};
    vt[8]  = '{3'd5, 32'h80000001, 32'h1,        32'h2,        4'b0010, 1};
    vt[9]  = '{3'd6, 32'h1,        32'h21,       32'h0,        4'b0110, 1};
    vt[10] = '{3'd5, 32'h12345678, 32'h20,       32'h12345678, 4'b0000, 1};
    vt[11] = '{3'd6, 32'h80000000, 32'h1F,       32'h1,        4'b0000, 1};
    vt[12] = '{3'd7, 32'h10000,    32'h10000,    32'h0,        4'b0110, 32};
    vt[13] = '{3'd7, 32'h7,        32'h6,        32'd42,       4'b0000, 32};
    vt[14] = '{3'd7, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 4'b1010, 32};
    RST = 1'b1; START = 1'b0; FUNC = 3'd0; SETF = 1'b0; OPERA = '0; OPERB = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_result", 64'(RESULT), 64'h0);
    chk("reset_flags", 64'({N, Z, C, V}), 64'h0);
    chk("reset_busy_done", 64'({BUSY, DONE}), 64'h0);

    for (int i = 0; i < 15; i++) begin
      op(vt[i].f, 1'b1, vt[i].a, vt[i].b, lat, busy);
      chk($sformatf("v%0d_result", i), 64'(RESULT), 64'(vt[i].r));
      chk($sformatf("v%0d_nzcv", i), 64'({N, Z, C, V}), 64'(vt[i].nzcv));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), 64'(busy), 64'(vt[i].lat));
    end

    @(negedge CLK);
    START = 1'b1; FUNC = 3'd7; SETF = 1'b1; OPERA = 32'd7; OPERB = 32'd6;
    @(negedge CLK);
    START = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) begin START = 1'b1; FUNC = 3'd0; OPERA = 32'd1; OPERB = 32'd1; end
      if (i == 5) START = 1'b0;
      @(negedge CLK);
      dones += int'(DONE);
    end
    chk("midmul_start_dones", 64'(dones), 64'd1);
    chk("midmul_start_result", 64'(RESULT), 64'd42);

    op(3'd1, 1'b1, 32'd5, 32'd5, lat, busy);
    chk("setf0_pre_flags", 64'({N, Z, C, V}), 64'b0110);
    op(3'd2, 1'b0, 32'hFF, 32'h0F, lat, busy);
    chk("setf0_result", 64'(RESULT), 64'h0F);
    chk("setf0_flags_held", 64'({N, Z, C, V}), 64'b0110);

    @(negedge CLK);
    START = 1'b1; FUNC = 3'd0; SETF = 1'b1; OPERA = 32'd1; OPERB = 32'd2;
    @(negedge CLK);
    FUNC = 3'd1; OPERA = 32'd10; OPERB = 32'd3;
    @(negedge CLK);
    chk("b2b_first_done", 64'(DONE), 64'd1);
    chk("b2b_first_result", 64'(RESULT), 64'd3);
    @(posedge CLK);
    #1 START = 1'b0;
    @(negedge CLK);
    chk("b2b_second_busy_done", 64'({BUSY, DONE}), 64'b10);
    @(negedge CLK);
    chk("b2b_second_done", 64'(DONE), 64'd1);
    chk("b2b_second_result", 64'(RESULT), 64'd7);
    chk("b2b_second_nzcv", 64'({N, Z, C, V}), 64'b0010);

    @(negedge CLK);
    START = 1'b1; FUNC = 3'd7; SETF = 1'b1; OPERA = 32'd7; OPERB = 32'd6;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_mul_busy_done", 64'({BUSY, DONE}), 64'h0);
    chk("rst_mul_result", 64'(RESULT), 64'h0);
    chk("rst_mul_flags", 64'({N, Z, C, V}), 64'h0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      dones += int'(DONE);
    end
    chk("rst_mul_no_done", 64'(dones), 64'd0);
    op(3'd7, 1'b1, 32'd7, 32'd6, lat, busy);
    chk("post_rst_mul_result", 64'(RESULT), 64'd42);
    chk("post_rst_mul_latency", 64'(lat), 64'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
